// File: rtl/local_history_predictor_if.sv
// Bundle of the predictor's fetch-side lookup, EX-side resolution and
// statistics signals.
//
// Handshake: is_branch_ex is a valid-only strobe. There is no ready; the
// predictor accepts a resolution on every rising clk edge where
// is_branch_ex=1. cmp_out_ex, pc_ex and pred_taken_ex are only
// meaningful while is_branch_ex=1. The pc_if lookup is purely
// combinational and needs no handshake.
//
// Modports:
//   master - pipeline side: drives pc_if, EX resolution and stat_clr.
//            Observes the prediction and statistics outputs.
//   slave  - predictor side: the mirror image of master.
interface local_history_predictor_if #(
  parameter int STAT_W = 16
);
  logic [31:0]       pc_if;
  logic              is_branch_ex;
  logic              cmp_out_ex;
  logic [31:0]       pc_ex;
  logic              pred_taken_ex;
  logic              stat_clr;
  logic              loc_predict_taken;
  logic              tag_match;
  logic              pred_conf;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output pc_if, is_branch_ex, cmp_out_ex, pc_ex, pred_taken_ex, stat_clr,
    input  loc_predict_taken, tag_match, pred_conf, branch_count,
           mispredict_count
  );

  modport slave (
    input  pc_if, is_branch_ex, cmp_out_ex, pc_ex, pred_taken_ex, stat_clr,
    output loc_predict_taken, tag_match, pred_conf, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/local_history_predictor.sv
// Two-level local-history branch direction predictor.
//
// A tagged branch history table (BHT) of N entries holds a per-branch
// shift register of recent outcomes. That history selects a saturating
// counter in a shared pattern history table (PHT). The lookup for pc_if is
// combinational, so it has zero-cycle latency. Resolutions from EX update
// the tables on the rising clk edge. A lookup that targets the same entry
// as a same-cycle update sees the old state.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset of all tables and statistics
//   bus  - local_history_predictor_if.slave:
//            pc_if, is_branch_ex, cmp_out_ex, pc_ex, pred_taken_ex,
//            stat_clr (in)
//            loc_predict_taken, tag_match, pred_conf, branch_count,
//            mispredict_count (out)
module local_history_predictor #(
  parameter int N      = 128,
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  local_history_predictor_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PHT_D = 1 << HIST_W;

  // Counters reset to weakly not-taken: 2^(CTR_W-1)-1.
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Table state
  logic [N-1:0]        r_valid;
  logic [TAG_W-1:0]    r_tag  [N];
  logic [HIST_W-1:0]   r_hist [N];
  logic [CTR_W-1:0]    r_pht  [PHT_D];
  logic [STAT_W-1:0]   r_branch_count;
  logic [STAT_W-1:0]   r_mispredict_count;

  // Fetch-side lookup
  logic [IDX_W-1:0]    w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;
  logic [CTR_W-1:0]    w_if_ctr;

  // EX-side update
  logic [IDX_W-1:0]    w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_ex_hit;
  logic [HIST_W-1:0]   w_ex_hist;
  logic [CTR_W-1:0]    w_ex_ctr;
  logic [CTR_W-1:0]    w_ctr_next;
  logic [HIST_W:0]     w_hist_shift;
  logic                w_mispredict;

  // The word-offset PC bits do not take part in indexing or tagging.
  logic                w_unused;
  assign w_unused = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  // Lookup
  assign w_if_idx = bus.pc_if[IDX_W+1:2];
  assign w_if_tag = bus.pc_if[31:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_ctr = r_pht[r_hist[w_if_idx]];

  assign bus.tag_match         = w_if_hit;
  assign bus.loc_predict_taken = w_if_hit && w_if_ctr[CTR_W-1];
  assign bus.pred_conf         = w_if_hit &&
                                 ((w_if_ctr == CTR_MAX) || (w_if_ctr == '0));
  assign bus.branch_count      = r_branch_count;
  assign bus.mispredict_count  = r_mispredict_count;

  // Update
  assign w_ex_idx  = bus.pc_ex[IDX_W+1:2];
  assign w_ex_tag  = bus.pc_ex[31:IDX_W+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_hist = r_hist[w_ex_idx];
  assign w_ex_ctr  = r_pht[w_ex_hist];

  // Shift the outcome in at the LSB and keep the low HIST_W bits. Going
  // through a HIST_W+1 wide vector also covers HIST_W=1.
  assign w_hist_shift = {w_ex_hist, bus.cmp_out_ex};
  assign w_mispredict = bus.pred_taken_ex != bus.cmp_out_ex;

  always_comb begin
    w_ctr_next = w_ex_ctr;
    if (bus.cmp_out_ex && (w_ex_ctr != CTR_MAX)) begin
      w_ctr_next = w_ex_ctr + CTR_W'(1);
    end else if (!bus.cmp_out_ex && (w_ex_ctr != '0)) begin
      w_ctr_next = w_ex_ctr - CTR_W'(1);
    end
  end

  // BHT / PHT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_tag   <= '{default: '0};
      r_hist  <= '{default: '0};
      r_pht   <= '{default: CTR_INIT};
    end else if (bus.is_branch_ex) begin
      if (w_ex_hit) begin
        r_pht[w_ex_hist] <= w_ctr_next;
        r_hist[w_ex_idx] <= w_hist_shift[HIST_W-1:0];
      end else begin
        // A miss replaces the entry. The shared PHT is left alone.
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_hist[w_ex_idx]  <= HIST_W'(bus.cmp_out_ex);
      end
    end
  end

  // Statistics: saturating. A clear beats a concurrent increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (bus.stat_clr) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (bus.is_branch_ex) begin
      if (r_branch_count != STAT_MAX) begin
        r_branch_count <= r_branch_count + STAT_W'(1);
      end
      if (w_mispredict && (r_mispredict_count != STAT_MAX)) begin
        r_mispredict_count <= r_mispredict_count + STAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_local_history_predictor.sv
// Self-checking bench for local_history_predictor (N=128, HIST_W=4,
// CTR_W=2, STAT_W=4). Checked vectors are
// {tag_match, loc_predict_taken, pred_conf, branch_count, mispredict_count}.
module tb_local_history_predictor;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  local_history_predictor_if #(.STAT_W(4)) bus ();

  local_history_predictor #(
    .N(128), .HIST_W(4), .CTR_W(2), .STAT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [10:0] w_act;
  assign w_act = {bus.tag_match, bus.loc_predict_taken, bus.pred_conf,
                  bus.branch_count, bus.mispredict_count};

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string name, input logic [10:0] act,
                     input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got tm/pt/pc/bc/mc=%b/%b/%b/%0d/%0d required %b/%b/%b/%0d/%0d",
               name, act[10], act[9], act[8], act[7:4], act[3:0],
               exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer tables: idx = (pc/4) mod 128, tag = pc/512.
  int m_valid[128];
  int m_tag[128];
  int m_hist[128];
  int m_pht[16];
  int m_bc;
  int m_mc;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_hist[i] = 0;
    end
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic logic [10:0] model_out(input logic [31:0] pif);
    int idx, tag, ctr;
    logic tm, pt, pc;
    idx = int'((pif / 4) % 128);
    tag = int'(pif / 512);
    tm  = (m_valid[idx] != 0) && (m_tag[idx] == tag);
    ctr = m_pht[m_hist[idx]];
    pt  = tm && (ctr >= 2);
    pc  = tm && (ctr == 3 || ctr == 0);
    return {tm, pt, pc, 4'(m_bc), 4'(m_mc)};
  endfunction

  task automatic model_step(input logic br, input logic [31:0] pex,
                            input logic cmp, input logic pred,
                            input logic clr);
    int idx, tag, h;
    if (clr) begin
      m_bc = 0;
      m_mc = 0;
    end else if (br) begin
      if (m_bc < 15) m_bc++;
      if (pred != cmp && m_mc < 15) m_mc++;
    end
    if (br) begin
      idx = int'((pex / 4) % 128);
      tag = int'(pex / 512);
      if (m_valid[idx] != 0 && m_tag[idx] == tag) begin
        h = m_hist[idx];
        if (cmp) m_pht[h] = (m_pht[h] < 3) ? m_pht[h] + 1 : 3;
        else     m_pht[h] = (m_pht[h] > 0) ? m_pht[h] - 1 : 0;
        m_hist[idx] = (h * 2 + int'(cmp)) % 16;
      end else begin
        m_valid[idx] = 1;
        m_tag[idx]   = tag;
        m_hist[idx]  = int'(cmp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic br, input logic [31:0] pex,
                       input logic cmp, input logic pred, input logic clr,
                       input logic [31:0] pif);
    bus.is_branch_ex  = br;
    bus.pc_ex         = pex;
    bus.cmp_out_ex    = cmp;
    bus.pred_taken_ex = pred;
    bus.stat_clr      = clr;
    bus.pc_if         = pif;
  endtask

  // One clock: drive at negedge, let the edge happen, update the model,
  // leave the caller 2 time units after the edge.
  task automatic cycle(input logic br, input logic [31:0] pex,
                       input logic cmp, input logic pred, input logic clr,
                       input logic [31:0] pif);
    @(negedge clk);
    drive(br, pex, cmp, pred, clr, pif);
    @(posedge clk);
    model_step(br, pex, cmp, pred, clr);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] idx_set[3];
    logic [31:0] idx, tag;
    idx_set[0] = 32'h40; idx_set[1] = 32'h41; idx_set[2] = 32'h05;
    idx = idx_set[$urandom_range(0, 2)];
    tag = 32'($urandom_range(0, 2));
    return (tag << 9) | (idx << 2) | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        br;
    logic [31:0] pex;
    logic        cmp;
    logic        pred;
    logic [31:0] pif;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic set_vec(input int i, input logic br, input logic [31:0] pex,
                         input logic cmp, input logic pred,
                         input logic [31:0] pif, input logic tm,
                         input logic pt, input logic pc, input int bc,
                         input int mc);
    tbl[i].br   = br;
    tbl[i].pex  = pex;
    tbl[i].cmp  = cmp;
    tbl[i].pred = pred;
    tbl[i].pif  = pif;
    tbl[i].exp  = {tm, pt, pc, 4'(bc), 4'(mc)};
  endtask

  // ---------------- test ----------------
  initial begin
    logic [10:0] prev_exp;
    logic [31:0] prev_pif;
    logic        br, cmp, pred, clr;
    logic [31:0] pex, pif;

    // training 0x100: allocate, walk 0001->0011->0111->1111, saturate
    set_vec(0,  1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1, 1);
    set_vec(1,  1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 2, 2);
    set_vec(2,  1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 3, 3);
    set_vec(3,  1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 4, 4);
    set_vec(4,  1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 5, 5);
    set_vec(5,  1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 6, 5);
    set_vec(6,  1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 7, 5);
    set_vec(7,  1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 7, 5);
    // not-taken run: drives counters down to 00 and holds there
    set_vec(8,  1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 8, 6);
    set_vec(9,  1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 9, 7);
    set_vec(10, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 10, 8);
    set_vec(11, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 11, 9);
    set_vec(12, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 12, 10);
    set_vec(13, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 13, 11);
    // conflicting tag at index 0x40 replaces the entry
    set_vec(14, 1'b1, 32'h300, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 14, 11);
    set_vec(15, 1'b0, 32'h0,   1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 1'b0, 14, 11);

    // --- reset state ---
    do_reset();
    #1;
    chk("reset_state", w_act, 11'b0);

    // --- table: post-edge value, plus the pre-edge value showing no bypass ---
    foreach (tbl[i]) exp_q.push_back(tbl[i].exp);
    prev_exp = 11'b0;
    prev_pif = 32'h100;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].br, tbl[i].pex, tbl[i].cmp, tbl[i].pred, 1'b0, tbl[i].pif);
      #1;
      if (tbl[i].pif == prev_pif) chk($sformatf("pre_edge_%0d", i), w_act, prev_exp);
      @(posedge clk);
      model_step(tbl[i].br, tbl[i].pex, tbl[i].cmp, tbl[i].pred, 1'b0);
      #2;
      prev_exp = exp_q.pop_front();
      prev_pif = tbl[i].pif;
      chk($sformatf("table_%0d", i), w_act, prev_exp);
    end

    // --- statistics saturation and clear priority ---
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cmp  = 1'($urandom_range(0, 1));
      pred = (i == 3 || i == 9 || i == 17) ? ~cmp : cmp;
      cycle(1'b1, 32'h2000 + 32'(i * 4), cmp, pred, 1'b0, 32'h0);
    end
    chk("stat_saturate", {3'b0, bus.branch_count, bus.mispredict_count},
        {3'b0, 4'd15, 4'd3});
    cycle(1'b1, 32'h2000, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("stat_clr_wins", {3'b0, bus.branch_count, bus.mispredict_count}, 11'b0);
    cycle(1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stat_after_clr", {3'b0, bus.branch_count, bus.mispredict_count},
        {3'b0, 4'd1, 4'd1});

    // --- asynchronous reset pulse mid-training ---
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100);
    chk("pre_async_rst", w_act, {1'b1, 1'b0, 1'b0, 4'd4, 4'd0});
    rst = 1'b1;
    #1;
    chk("async_rst_clear", w_act, 11'b0);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100);
    chk("post_rst_miss", w_act, 11'b0);

    // --- randomized run against the model ---
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      br   = 1'($urandom_range(0, 3) != 0);
      pex  = rand_pc();
      cmp  = 1'($urandom_range(0, 1));
      pred = 1'($urandom_range(0, 1));
      clr  = 1'($urandom_range(0, 19) == 0);
      pif  = ($urandom_range(0, 1) == 1) ? pex : rand_pc();
      drive(br, pex, cmp, pred, clr, pif);
      #1;
      exp_q.push_back(model_out(pif));
      chk($sformatf("rand_%0d", i), w_act, exp_q.pop_front());
      @(posedge clk);
      model_step(br, pex, cmp, pred, clr);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/local_history_predictor.md
LOCAL_HISTORY_PREDICTOR -- requirements
Module: local_history_predictor

Interface
REQ-001 SHALL have parameter N, default 128: branch history table (BHT) entries, power of two, n = log2(N).
REQ-002 SHALL have parameter HIST_W, default 4: local history bits per BHT entry; pattern history table (PHT) depth is 2^HIST_W.
REQ-003 SHALL have parameter CTR_W, default 2: PHT saturating counter width, >= 2.
REQ-004 SHALL have parameter STAT_W, default 16: statistics counter width.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port pc_if, input, 32 bits: fetch PC to predict.
REQ-008 SHALL have port is_branch_ex, input, 1 bit: a resolved conditional branch is in EX this cycle.
REQ-009 SHALL have port cmp_out_ex, input, 1 bit: actual outcome, 1 = taken.
REQ-010 SHALL have port pc_ex, input, 32 bits: PC of the resolving branch.
REQ-011 SHALL have port pred_taken_ex, input, 1 bit: prediction issued for that branch.
REQ-012 SHALL have port stat_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-013 SHALL have port loc_predict_taken, output, 1 bit: predicted direction for pc_if.
REQ-014 SHALL have port tag_match, output, 1 bit: pc_if hits a valid BHT entry.
REQ-015 SHALL have port pred_conf, output, 1 bit: prediction comes from a saturated counter.
REQ-016 SHALL have port branch_count, output, STAT_W bits: resolved branches.
REQ-017 SHALL have port mispredict_count, output, STAT_W bits: mispredictions.

Function
REQ-018 SHALL index the BHT with pc[n+1:2] and tag it with pc[31:n+2]; each entry holds valid, tag and HIST_W-bit history.
REQ-019 SHALL compute all outputs combinationally from pc_if and the current state, giving zero-cycle read latency.
REQ-020 SHALL assert tag_match = valid && tag equal for the pc_if entry.
REQ-021 SHALL assert loc_predict_taken = tag_match && MSB of PHT[entry history], and SHALL drive 0 on a miss.
REQ-022 SHALL assert pred_conf = tag_match && PHT counter at all-ones or all-zeros.
REQ-023 SHALL apply the following on an is_branch_ex hit (valid, tag match at pc_ex): PHT[history] +1 if taken, -1 if not, saturating at 2^CTR_W-1 and 0; history <= {history[HIST_W-2:0], cmp_out_ex}.
REQ-024 SHALL apply the following on an is_branch_ex miss: allocate/replace the entry with valid=1, tag=pc_ex tag, history = zero-extended cmp_out_ex; PHT unchanged.
REQ-025 SHALL NOT bypass a same-cycle update to an identical pc_if index: the read returns the pre-update state and the new state is visible the next cycle.
REQ-026 SHALL leave all state unchanged when is_branch_ex=0; cmp_out_ex, pc_ex and pred_taken_ex are don't-care.
REQ-027 SHALL increment branch_count on every is_branch_ex, and mispredict_count when is_branch_ex && pred_taken_ex != cmp_out_ex; both saturate at all-ones.
REQ-028 SHALL let stat_clr win over a simultaneous increment (result 0), and SHALL NOT let it affect the BHT or PHT.

Reset
REQ-029 SHALL, on rst assertion and without waiting for a clock edge, clear all BHT valid, tag and history bits, set every PHT counter to 2^(CTR_W-1)-1 (weakly not-taken), and zero both statistics counters.
REQ-030 SHALL hold that state while rst=1, ignoring is_branch_ex and stat_clr, with outputs tag_match=0, loc_predict_taken=0, pred_conf=0, counts=0.
REQ-031 SHALL resume normal updates on the first rising clk edge after rst deasserts.

Verification (N=128, HIST_W=4, CTR_W=2, STAT_W=4)
REQ-032 SHALL cover: after reset, pc_if=0x100 -> tag_match=0, loc_predict_taken=0, pred_conf=0, both counts 0.
REQ-033 SHALL cover: five taken resolutions at pc_ex=0x100 -> allocate hist=0001; PHT[0001], PHT[0011], PHT[0111] each 01->10; hist 1111; PHT[1111] 01->10. Then pc_if=0x100 -> tag_match=1, loc_predict_taken=1, pred_conf=0.
REQ-034 SHALL cover: two further taken resolutions at 0x100 -> PHT[1111]=11, pred_conf=1; a third taken leaves 11. Symmetric not-taken drives a counter to 00 and it holds.
REQ-035 SHALL cover: resolve at 0x300 (same index 0x40, different tag) after training 0x100 -> entry replaced; pc_if=0x100 gives tag_match=0 and loc_predict_taken=0.
REQ-036 SHALL cover: 20 branches with 3 mismatches -> branch_count=15 (saturated), mispredict_count=3; stat_clr with a concurrent branch -> both 0 next cycle.
REQ-037 SHALL cover: rst pulsed between clock edges mid-training -> outputs and counts cleared before the next edge, and pc_if=0x100 misses afterward.
